// File: rtl/fpu_col_feeder.sv
// Producer side of the FPU column window buffer: packs a column-major pixel stream
// into ROWS-tall columns, pulses shift_rows per column and hands 3-column windows to the FPU.
module fpu_col_feeder #(
    parameter int ROWS  = 10,
    parameter int PIX_W = 8,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    img_width,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic [PIX_W-1:0] col_new [ROWS-1:0],
    output logic             shift_rows,
    output logic             window_valid,
    input  logic             fpu_ready,
    output logic [CW-1:0]    win_idx,
    output logic             busy,
    output logic             done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {IDLE, FILL, SHIFT, WAIT, DONE} state_t;

    state_t          state_reg;
    logic [RW-1:0]   row_idx_reg;
    logic [CW-1:0]   cols_loaded_reg;
    logic [CW-1:0]   width_reg;
    logic [CW-1:0]   cols_inc;
    logic            accept;

    // in_ready is a registered copy of (state == FILL), so it is safe to qualify with it
    assign accept   = in_valid && in_ready;
    assign cols_inc = cols_loaded_reg + CW'(1);

    // One holding register per row; each is written only when its row is the one being accepted.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [PIX_W-1:0] pix_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pix_reg <= '0;
            end else if (accept && (row_idx_reg == RW'(gi))) begin
                pix_reg <= in_pixel;
            end
        end

        assign col_new[gi] = pix_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            row_idx_reg     <= '0;
            cols_loaded_reg <= '0;
            width_reg       <= '0;
            in_ready        <= 1'b0;
            shift_rows      <= 1'b0;
            window_valid    <= 1'b0;
            win_idx         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (img_width >= CW'(3)) begin
                            width_reg       <= img_width;
                            row_idx_reg     <= '0;
                            cols_loaded_reg <= '0;
                            in_ready        <= 1'b1;
                            state_reg       <= FILL;
                        end else begin
                            // Too narrow for a single window: finish without touching the buffer
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (row_idx_reg == RW'(ROWS - 1)) begin
                            row_idx_reg <= '0;
                            in_ready    <= 1'b0;
                            shift_rows  <= 1'b1;
                            state_reg   <= SHIFT;
                        end else begin
                            row_idx_reg <= row_idx_reg + RW'(1);
                        end
                    end
                end
                SHIFT: begin
                    shift_rows      <= 1'b0;
                    cols_loaded_reg <= cols_inc;
                    if (cols_inc >= CW'(3)) begin
                        window_valid <= 1'b1;
                        win_idx      <= cols_inc - CW'(2);
                        state_reg    <= WAIT;
                    end else begin
                        in_ready  <= 1'b1;
                        state_reg <= FILL;
                    end
                end
                WAIT: begin
                    if (fpu_ready) begin
                        window_valid <= 1'b0;
                        if (cols_loaded_reg == width_reg) begin
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            in_ready  <= 1'b1;
                            state_reg <= FILL;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    in_ready     <= 1'b0;
                    shift_rows   <= 1'b0;
                    window_valid <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_col_feeder.sv
// Bench for fpu_col_feeder: table-driven frames, a mid-frame reset sequence and
// randomized frames checked against stream-level expectations.
module tb_fpu_col_feeder;
    localparam int ROWS   = 10;
    localparam int PIX_W  = 8;
    localparam int CW     = 16;
    localparam int MAXPIX = 256;
    localparam int TMO    = 5000;

    typedef struct {
        int width;
        int vmode;        // 0: in_valid always 1, 1: toggling, 2: random
        int stall;        // fpu_ready low cycles per window
        bit glitch;       // stray start / fpu_ready pulses
        int exp_shifts;
        int exp_windows;
        int exp_accepts;
        int exp_done;     // cycle of done pulse after start, -1 = not fixed
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CW-1:0]    img_width = '0;
    logic             in_valid = 1'b0;
    logic [PIX_W-1:0] in_pixel = '0;
    logic             in_ready;
    logic [PIX_W-1:0] col_new [ROWS-1:0];
    logic             shift_rows;
    logic             window_valid;
    logic             fpu_ready = 1'b0;
    logic [CW-1:0]    win_idx;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    logic [PIX_W-1:0] pix [MAXPIX];

    always #5 clk = ~clk;

    fpu_col_feeder #(.ROWS(ROWS), .PIX_W(PIX_W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_width(img_width),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
        .col_new(col_new), .shift_rows(shift_rows), .window_valid(window_valid),
        .fpu_ready(fpu_ready), .win_idx(win_idx), .busy(busy), .done(done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit all_zero();
        bit z;
        z = !(in_ready || shift_rows || window_valid || done || busy) && (win_idx == '0);
        for (int r = 0; r < ROWS; r++) if (col_new[r] != '0) z = 1'b0;
        return z;
    endfunction

    function automatic logic pick_valid(input int vmode, input int c);
        if (vmode == 0) return 1'b1;
        if (vmode == 1) return (c % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_frame(input int tag, input vec_t v);
        int c, acc, shifts, windows, dones, wait_cnt, irdy_cycles, exp_cyc;
        bit prev_wv, prev_fr, finished, col_ok;
        c = 0; acc = 0; shifts = 0; windows = 0; dones = 0; wait_cnt = 0; irdy_cycles = 0;
        prev_wv = 0; prev_fr = 0; finished = 0;
        start     = 1'b1;
        img_width = CW'(v.width);
        in_valid  = pick_valid(v.vmode, c);
        in_pixel  = pix[0];
        fpu_ready = v.glitch;
        if (in_ready && in_valid) acc++;
        while (!finished && c < TMO) begin
            @(posedge clk); #1;
            c++;
            if (dones > 0) begin
                check($sformatf("busy_after_done_f%0d", tag), busy, 0);
                check($sformatf("done_single_f%0d", tag), done, 0);
                finished = 1;
                start = 1'b0; in_valid = 1'b0; fpu_ready = 1'b0;
            end else begin
                if (in_ready) irdy_cycles++;
                if (shift_rows) begin
                    col_ok = 1;
                    for (int r = 0; r < ROWS; r++)
                        if ((shifts + 1) * ROWS > MAXPIX || col_new[r] != pix[shifts * ROWS + r]) col_ok = 0;
                    check($sformatf("col%0d_f%0d", shifts, tag), col_ok, 1);
                    if (v.vmode == 0) begin
                        exp_cyc = (ROWS + 1) * (shifts + 1) + ((shifts > 2) ? (shifts - 2) : 0) * (v.stall + 1);
                        check($sformatf("shift%0d_cycle_f%0d", shifts, tag), c, exp_cyc);
                    end
                    shifts++;
                end
                if (prev_wv && !prev_fr) check($sformatf("wv_hold_f%0d", tag), window_valid, 1);
                if (prev_wv && prev_fr)  check($sformatf("wv_drop_f%0d", tag), window_valid, 0);
                if (window_valid) begin
                    check($sformatf("irdy_in_wait_f%0d", tag), in_ready, 0);
                    if (wait_cnt == 0) check($sformatf("win_idx%0d_f%0d", windows, tag), win_idx, windows + 1);
                    wait_cnt++;
                    fpu_ready = (wait_cnt > v.stall);
                    if (fpu_ready) begin
                        windows++;
                        wait_cnt = 0;
                    end
                end else begin
                    fpu_ready = v.glitch && (c % 3 == 0);
                end
                prev_wv = window_valid;
                prev_fr = fpu_ready;
                if (done) begin
                    dones++;
                    if (v.exp_done >= 0) check($sformatf("done_cycle_f%0d", tag), c, v.exp_done);
                end
                start     = v.glitch && !done && (c % 5 == 2);
                img_width = start ? CW'(7) : CW'(v.width);
                in_valid  = pick_valid(v.vmode, c);
                in_pixel  = pix[acc % MAXPIX];
                if (in_ready && in_valid) acc++;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout_f%0d: got no done within %0d cycles", tag, TMO);
        end
        start = 1'b0; in_valid = 1'b0; fpu_ready = 1'b0;
        check($sformatf("shifts_f%0d", tag), shifts, v.exp_shifts);
        check($sformatf("windows_f%0d", tag), windows, v.exp_windows);
        check($sformatf("accepts_f%0d", tag), acc, v.exp_accepts);
        check($sformatf("dones_f%0d", tag), dones, 1);
        if (v.width < 3) check($sformatf("irdy_cycles_f%0d", tag), irdy_cycles, 0);
        $display("frame %0d: width=%0d vmode=%0d stall=%0d glitch=%0d shifts=%0d windows=%0d accepts=%0d",
                 tag, v.width, v.vmode, v.stall, v.glitch, shifts, windows, acc);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl [7];
        vec_t rv;
        int   n, guard;

        tbl[0] = '{3, 0, 0, 1'b0, 3, 1, 30, 35};
        tbl[1] = '{5, 0, 7, 1'b0, 5, 3, 50, 80};
        tbl[2] = '{4, 1, 0, 1'b0, 4, 2, 40, -1};
        tbl[3] = '{2, 0, 0, 1'b0, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 0, 1'b0, 0, 0, 0, 1};
        tbl[5] = '{3, 0, 0, 1'b1, 3, 1, 30, 35};
        tbl[6] = '{4, 0, 2, 1'b1, 4, 2, 40, 51};

        for (int k = 0; k < MAXPIX; k++) pix[k] = PIX_W'(k);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", all_zero(), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // Reset in the middle of the first column after 4 accepted pixels
        start = 1'b1; img_width = CW'(3); in_valid = 1'b1; in_pixel = pix[0];
        n = 0; guard = 0;
        while (n < 4 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
            start = 1'b0;
            if (in_ready && in_valid) n++;
            in_pixel = pix[n];
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midfill_reset_zero", all_zero(), 1);
        $display("reset mid-FILL after %0d accepts", n);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(100, tbl[0]);

        foreach (tbl[i]) run_frame(i, tbl[i]);

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < MAXPIX; k++) pix[k] = PIX_W'($urandom);
            rv.width  = $urandom_range(0, 6);
            rv.vmode  = $urandom_range(0, 2);
            rv.stall  = $urandom_range(0, 3);
            rv.glitch = 1'($urandom_range(0, 1));
            rv.exp_shifts  = (rv.width >= 3) ? rv.width : 0;
            rv.exp_windows = (rv.width >= 3) ? rv.width - 2 : 0;
            rv.exp_accepts = (rv.width >= 3) ? rv.width * ROWS : 0;
            if (rv.width < 3)        rv.exp_done = 1;
            else if (rv.vmode == 0)  rv.exp_done = (ROWS + 1) * rv.width + (rv.width - 2) * (rv.stall + 1) + 1;
            else                     rv.exp_done = -1;
            run_frame(200 + f, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
